// File: rtl/ext_ctrl_pkg.sv
// ext_ctrl_pkg: shared state encoding and default parameters for the razor extension controller
package ext_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_PIPE = 2;
   localparam int DEF_MAX_RETRY = 3;
   localparam int DEF_ERR_HI = 4;
endpackage

// File: rtl/ext_razor_ctrl_if.sv
// ext_razor_ctrl_if: frame request, step issue and result/voltage signals of the razor controller
interface ext_razor_ctrl_if
   import ext_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W = DEF_CNT_W
) ();
   logic start;
   logic abort;
   logic [ADDR_W-1:0] frame_len;
   logic err_in;
   logic issue_en;
   logic [ADDR_W-1:0] issue_addr;
   logic ext_valid;
   logic [ADDR_W-1:0] ext_addr;
   logic busy;
   logic done;
   logic [CNT_W-1:0] err_count;
   logic retry_fail;
   logic volt_up;
   logic volt_down;
   modport master (
      output start, abort, frame_len, err_in,
      input issue_en, issue_addr, ext_valid, ext_addr, busy, done, err_count, retry_fail, volt_up, volt_down
   );
   modport slave (
      input start, abort, frame_len, err_in,
      output issue_en, issue_addr, ext_valid, ext_addr, busy, done, err_count, retry_fail, volt_up, volt_down
   );
endinterface

// File: rtl/ext_inflight_pipe.sv
// ext_inflight_pipe: PIPE-deep {valid,addr} tracker of issued steps awaiting their result
module ext_inflight_pipe #(
   parameter int ADDR_W = 10,
   parameter int PIPE = 2
) (
   input  logic Clock,
   input  logic nReset,
   input  logic flush,
   input  logic in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic out_valid,
   output logic [ADDR_W-1:0] out_addr
);
   logic [PIPE-1:0] vld;
   logic [ADDR_W-1:0] adr [PIPE];
   // shift issues toward the result end; flush also drops the step issued this cycle
   always_ff @(posedge Clock or negedge nReset)
      if (!nReset) begin
         vld <= '0;
         for (int i = 0; i < PIPE; i++) adr[i] <= '0;
      end else begin
         vld[0] <= in_valid & ~flush;
         adr[0] <= in_addr;
         for (int i = 1; i < PIPE; i++) begin
            vld[i] <= vld[i-1] & ~flush;
            adr[i] <= adr[i-1];
         end
      end
   assign out_valid = vld[PIPE-1];
   assign out_addr = adr[PIPE-1];
endmodule

// File: rtl/ext_razor_ctrl.sv
// ext_razor_ctrl: issues trellis steps, accepts or replays results on razor errors, requests voltage changes
module ext_razor_ctrl
   import ext_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int PIPE = DEF_PIPE,
   parameter int MAX_RETRY = DEF_MAX_RETRY,
   parameter int ERR_HI = DEF_ERR_HI
) (
   input logic Clock,
   input logic nReset,
   ext_razor_ctrl_if.slave bus
);
   localparam int RW = $clog2(MAX_RETRY + 1);
   state_t state;
   logic [ADDR_W-1:0] ptr, last, ret_addr;
   logic [RW-1:0] retry;
   logic [CNT_W-1:0] err_cnt;
   logic rfail, ret_valid, act, kill, err_hit, give_up, replay, accept;
   assign act = state == ISSUE || state == DRAIN;
   assign kill = act && bus.abort;
   assign err_hit = ret_valid && bus.err_in && !kill;
   assign give_up = err_hit && retry == RW'(MAX_RETRY - 1);
   assign replay = err_hit && !give_up;
   assign accept = ret_valid && !kill && (!bus.err_in || give_up);
   ext_inflight_pipe #(.ADDR_W(ADDR_W), .PIPE(PIPE)) u_pipe (
      .Clock(Clock),
      .nReset(nReset),
      .flush(replay || kill),
      .in_valid(state == ISSUE),
      .in_addr(ptr),
      .out_valid(ret_valid),
      .out_addr(ret_addr)
   );
   // frame sequencing, replay from the errored step, per-frame error bookkeeping
   always_ff @(posedge Clock or negedge nReset)
      if (!nReset) begin
         state <= IDLE;
         ptr <= '0;
         last <= '0;
         retry <= '0;
         err_cnt <= '0;
         rfail <= 1'b0;
      end else if (state == IDLE) begin
         if (bus.start) begin
            state <= bus.frame_len == '0 ? DONE : ISSUE;
            ptr <= '0;
            last <= bus.frame_len - ADDR_W'(1);
            retry <= '0;
            err_cnt <= '0;
            rfail <= 1'b0;
         end
      end else if (state == DONE) begin
         state <= IDLE;
      end else if (kill) begin
         state <= IDLE;
         retry <= '0;
      end else begin
         if (err_hit && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
         if (give_up) rfail <= 1'b1;
         retry <= accept ? '0 : replay ? retry + RW'(1) : retry;
         if (replay) begin
            ptr <= ret_addr;
            state <= ISSUE;
         end else if (state == ISSUE) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == last) state <= DRAIN;
         end else if (accept && ret_addr == last) begin
            state <= DONE;
         end
      end
   assign bus.issue_en = state == ISSUE;
   assign bus.issue_addr = ptr;
   assign bus.ext_valid = accept;
   assign bus.ext_addr = ret_addr;
   assign bus.busy = act;
   assign bus.done = state == DONE;
   assign bus.err_count = err_cnt;
   assign bus.retry_fail = rfail;
   assign bus.volt_up = state == DONE && int'(err_cnt) >= ERR_HI;
   assign bus.volt_down = state == DONE && err_cnt == '0;
endmodule

// File: doc/ext_razor_ctrl.md
EXT_RAZOR_CTRL -- requirements
Module: ext_razor_ctrl

Interface
REQ-001 Parameters: ADDR_W=10, frame address width; CNT_W=8, error counter width; PIPE=2, issue-to-result latency in cycles; MAX_RETRY=3, consecutive errors tolerated per step; ERR_HI=4, per-frame errors that raise volt_up.
REQ-002 Clock  in  1  clock; all flops rising-edge.
REQ-003 nReset  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  frame request, sampled only in IDLE.
REQ-005 abort  in  1  terminate frame; in-flight results discarded.
REQ-006 frame_len  in  ADDR_W  trellis steps in frame, sampled with accepted start.
REQ-007 err_in  in  1  razor error (Error_current_be1) for the result returning this cycle.
REQ-008 issue_en  out  1  step operands requested this cycle.
REQ-009 issue_addr  out  ADDR_W  step index for alpha/beta fetch.
REQ-010 ext_valid  out  1  be1_DFF this cycle is an accepted result.
REQ-011 ext_addr  out  ADDR_W  step index of accepted result.
REQ-012 busy  out  1  high in ISSUE and DRAIN.
REQ-013 done  out  1  one-cycle frame-complete pulse.
REQ-014 err_count  out  CNT_W  saturating razor error count for current/last frame.
REQ-015 retry_fail  out  1  sticky per frame: a step was accepted after MAX_RETRY errors.
REQ-016 volt_up, volt_down  out  1 each  voltage-scaling requests, pulsed with done.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start with frame_len>0; IDLE->DONE on start with frame_len=0 (no issues); start ignored outside IDLE.
REQ-018 In ISSUE, issue_en=1 every cycle, issue_addr 0,1,... incrementing by one; after issuing frame_len-1, ISSUE->DRAIN.
REQ-019 Result of issue at cycle c returns at cycle c+PIPE; a PIPE-deep {valid,addr} shift register tracks in-flight issues.
REQ-020 Returning entry with valid=1 and err_in=0: ext_valid=1, ext_addr=entry addr, consecutive-retry counter cleared.
REQ-021 Returning entry with valid=1 and err_in=1 and retry count <MAX_RETRY-1: ext_valid=0, err_count+1 (saturate at 2^CNT_W-1), retry count+1, all in-flight valid bits (including entry issued this cycle) cleared, issue pointer set to errored addr, state forced to ISSUE from next cycle (also from DRAIN).
REQ-022 err_in=1 on the MAX_RETRY-th consecutive error for same addr: result accepted (ext_valid=1), err_count+1, retry_fail set, no replay.
REQ-023 err_in ignored when returning entry valid=0.
REQ-024 DRAIN->DONE the cycle after the result for addr frame_len-1 is accepted; DONE lasts one cycle (done=1), then IDLE.
REQ-025 In DONE: volt_up=1 if err_count>=ERR_HI; volt_down=1 if err_count=0; else both 0.
REQ-026 err_count and retry_fail cleared on accepted start, held otherwise, including through IDLE.
REQ-027 abort in ISSUE/DRAIN: next cycle IDLE, all valid bits cleared, no done/volt pulse, err_count held; abort in IDLE/DONE ignored; abort has priority over err_in in same cycle.

Reset
REQ-028 nReset low: state IDLE, all outputs 0, issue pointer 0, in-flight valid bits 0, counters 0; deassertion synchronous to Clock.

Structure
REQ-029 State enum, PIPE, MAX_RETRY and ERR_HI defaults in shared package ext_ctrl_pkg.
REQ-030 One sub-module: ext_inflight_pipe (PIPE-deep {valid,addr} shift register with flush).

Verification
REQ-031 frame_len=8, no errors, start at c0 -> issue_addr 0..7 at c1..c8, ext_valid c3..c10, done c11, volt_down=1.
REQ-032 frame_len=4, err_in at c4 (addr 1) -> issues 0,1,2,3,1,2,3 at c1..c7; accepted 0@c3,1@c7,2@c8,3@c9; done c10; err_count=1.
REQ-033 frame_len=2, err_in on every addr-0 return -> two replays, third error accepted, retry_fail=1, err_count=3, done still issued.
REQ-034 frame_len=16, five isolated errors -> done with volt_up=1, err_count=5; next start clears err_count to 0.
REQ-035 abort at c5 of frame_len=8 -> IDLE at c6, no ext_valid after c5, no done; nReset mid-frame -> all outputs 0 asynchronously.
